// File: rtl/pulse_synth_pkg.sv
// -----------------------------------------------------------------------------
// pulse_synth_pkg
// Shared types and constants for the pulse-rate synthesizer.
//   state_e      : controller states (IDLE, CONV, APPLY, RUN)
//   ST_*         : the same encodings as plain 2-bit constants for the FSM
//   BCD_DIGITS   : number of packed BCD digits carried on freq
//   MAX_FREQ     : largest rate the 16-bit freq field can request
// -----------------------------------------------------------------------------
package pulse_synth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    APPLY = 2'd2,
    RUN   = 2'd3
  } state_e;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_CONV  = CONV;
  localparam logic [1:0] ST_APPLY = APPLY;
  localparam logic [1:0] ST_RUN   = RUN;

  localparam int          BCD_DIGITS = 4;
  localparam logic [15:0] MAX_FREQ   = 16'hFFFF;

endpackage

// File: rtl/pulse_synth_if.sv
// -----------------------------------------------------------------------------
// pulse_synth_if
// Control/stream bundle between a rate source and pulse_synth.
//   en       : run enable (master -> slave)
//   load     : one-cycle strobe capturing freq (master -> slave)
//   freq     : requested rate, binary or packed BCD (master -> slave)
//   busy     : load in progress, further loads ignored (slave -> master)
//   ceo      : one-cycle output pulse stream (slave -> master)
//   sec_tick : one-cycle 1 s gate marker (slave -> master)
//   err      : sticky invalid BCD digit flag (slave -> master)
// -----------------------------------------------------------------------------
interface pulse_synth_if;
  import pulse_synth_pkg::*;

  logic                    en;
  logic                    load;
  logic [4*BCD_DIGITS-1:0] freq;
  logic                    busy;
  logic                    ceo;
  logic                    sec_tick;
  logic                    err;

  modport master (
    output en, load, freq,
    input  busy, ceo, sec_tick, err
  );

  modport slave (
    input  en, load, freq,
    output busy, ceo, sec_tick, err
  );

endinterface

// File: rtl/pulse_synth_bcd2bin.sv
// -----------------------------------------------------------------------------
// pulse_synth_bcd2bin
// Sequential packed-BCD to binary converter, one digit per cycle, MSD first,
// r <= r*10 + digit computed as (r<<3)+(r<<1)+digit. Digits above 9 are
// clamped to 9 and flagged on o_err, which holds until the next i_start.
// Only present when PULSE_SYNTH_BCD_IN_EN is defined.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   i_start  : capture i_bcd and begin conversion
//   i_bcd    : packed BCD digits
//   o_bin    : binary result (valid after o_done)
//   o_done   : high during the last digit cycle
//   o_err    : sticky clamp flag for the current conversion
// -----------------------------------------------------------------------------
`ifdef PULSE_SYNTH_BCD_IN_EN
module pulse_synth_bcd2bin
  import pulse_synth_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [4*BCD_DIGITS-1:0] i_bcd,
  output logic [15:0]             o_bin,
  output logic                    o_done,
  output logic                    o_err
);

  localparam int         CNT_W    = $clog2(BCD_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCD_DIGITS - 1);

  logic [4*BCD_DIGITS-1:0] r_shift;
  logic [15:0]             r_bin;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_active;
  logic                    r_err;

  logic [4*BCD_DIGITS-1:0] w_clamped;
  logic [BCD_DIGITS-1:0]   w_bad;
  logic [15:0]             w_bin_next;

  // All digits are clamped at capture so the serial loop only ever sees 0..9.
  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
    assign w_bad[gi]               = (i_bcd[4*gi+3 -: 4] > 4'd9);
    assign w_clamped[4*gi+3 -: 4]  = w_bad[gi] ? 4'd9 : i_bcd[4*gi+3 -: 4];
  end

  assign w_bin_next = (r_bin << 3) + (r_bin << 1)
                    + {12'd0, r_shift[4*BCD_DIGITS-1 -: 4]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift  <= '0;
      r_bin    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_err    <= 1'b0;
    end else if (i_start) begin
      r_shift  <= w_clamped;
      r_bin    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b1;
      r_err    <= |w_bad;
    end else if (r_active) begin
      r_bin   <= w_bin_next;
      r_shift <= r_shift << 4;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (r_cnt == CNT_LAST) begin
        r_active <= 1'b0;
      end
    end
  end

  assign o_bin  = r_bin;
  assign o_done = r_active && (r_cnt == CNT_LAST);
  assign o_err  = r_err;

endmodule
`endif

// File: rtl/pulse_synth.sv
// -----------------------------------------------------------------------------
// pulse_synth
// Programmable pulse-rate synthesizer. A phase accumulator adds the active
// rate every enabled cycle and emits a one-cycle ceo strobe each time it
// crosses CLK_FREQ; a gate counter emits sec_tick every CLK_FREQ enabled
// cycles. Both restart together when a new rate is applied, so exactly f_act
// pulses fall in each gate window (the pulse coincident with the closing tick
// counts as inside).
// Optional feature: PULSE_SYNTH_BCD_IN_EN selects packed-BCD freq input with a
// 4-cycle serial conversion and a sticky err flag for clamped digits.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : pulse_synth_if.slave (en, load, freq in; busy, ceo, sec_tick, err out)
// Parameters:
//   CLK_FREQ : clock rate in Hz, must exceed 65535
//   ACC_W    : accumulator width, 2^ACC_W > CLK_FREQ + 65535
// -----------------------------------------------------------------------------
module pulse_synth
  import pulse_synth_pkg::*;
#(
  parameter int CLK_FREQ = 27_000_000,
  parameter int ACC_W    = 32
) (
  input  logic          clk,
  input  logic          rst,
  pulse_synth_if.slave  bus
);

  if (CLK_FREQ <= int'(MAX_FREQ)) begin : g_bad_clk_freq
    $error("pulse_synth: CLK_FREQ must exceed 65535");
  end
  if ((ACC_W < 63) &&
      ((longint'(1) << ACC_W) <= (longint'(CLK_FREQ) + longint'(MAX_FREQ)))) begin : g_bad_acc_w
    $error("pulse_synth: ACC_W too narrow for CLK_FREQ + 65535");
  end

  localparam int               CNT_W    = $clog2(CLK_FREQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_FREQ - 1);
  localparam logic [ACC_W-1:0] ACC_CLK  = ACC_W'(CLK_FREQ);

  logic [1:0]       r_state;
  logic [15:0]      r_f_act;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_sec_cnt;
  logic             r_ceo;
  logic             r_sec_tick;

  logic [1:0]       w_state_next;
  logic             w_busy;
  logic             w_accept;
  logic             w_gen_en;
  logic             w_conv_done;
  logic [15:0]      w_new_freq;
  logic [ACC_W-1:0] w_sum;
  logic             w_cross;

  assign w_busy   = (r_state == ST_CONV) || (r_state == ST_APPLY);
  assign w_accept = bus.load && !w_busy;
  // Loading is gated by state; generation runs in both IDLE and RUN.
  assign w_gen_en = bus.en && ((r_state == ST_IDLE) || (r_state == ST_RUN));

  // Cannot overflow: r_acc < CLK_FREQ and r_f_act <= 65535.
  assign w_sum   = r_acc + {{(ACC_W-16){1'b0}}, r_f_act};
  assign w_cross = (w_sum >= ACC_CLK);

`ifdef PULSE_SYNTH_BCD_IN_EN
  localparam logic [1:0] ST_LOAD_DEST = ST_CONV;
  logic w_conv_err;

  pulse_synth_bcd2bin u_bcd2bin (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_accept),
    .i_bcd   (bus.freq),
    .o_bin   (w_new_freq),
    .o_done  (w_conv_done),
    .o_err   (w_conv_err)
  );

  assign bus.err = w_conv_err;
`else
  localparam logic [1:0] ST_LOAD_DEST = ST_APPLY;
  logic [15:0] r_f_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f_pend <= '0;
    end else if (w_accept) begin
      r_f_pend <= bus.freq;
    end
  end

  assign w_new_freq  = r_f_pend;
  assign w_conv_done = 1'b1;
  assign bus.err     = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_RUN: if (w_accept) w_state_next = ST_LOAD_DEST;
      ST_CONV:         if (w_conv_done) w_state_next = ST_APPLY;
      ST_APPLY:        w_state_next = ST_RUN;
      default:         w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_f_act    <= '0;
      r_acc      <= '0;
      r_sec_cnt  <= '0;
      r_ceo      <= 1'b0;
      r_sec_tick <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ceo      <= 1'b0;
      r_sec_tick <= 1'b0;
      if (r_state == ST_APPLY) begin
        // Phase and gate restart together so no partial pulse survives.
        r_f_act   <= w_new_freq;
        r_acc     <= '0;
        r_sec_cnt <= '0;
      end else if (w_gen_en) begin
        if (w_cross) begin
          r_acc <= w_sum - ACC_CLK;
          r_ceo <= 1'b1;
        end else begin
          r_acc <= w_sum;
        end
        if (r_sec_cnt == CNT_LAST) begin
          r_sec_cnt  <= '0;
          r_sec_tick <= 1'b1;
        end else begin
          r_sec_cnt <= r_sec_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.busy     = w_busy;
  assign bus.ceo      = r_ceo;
  assign bus.sec_tick = r_sec_tick;

endmodule

// File: doc/pulse_synth.md
Name: pulse_synth

Overview:
- Programmable pulse-rate synthesizer; the transmit-side counterpart of the frequency meter.
- Takes a target rate in pulses per second and emits evenly spaced one-clock `ceo` strobes at exactly that rate, measured against an internal 1 s gate.
- Also emits a 1 Hz `sec_tick` aligned to the pulse phase, so that exactly FREQ pulses fall inside every gate window.
- Feeds the meter's `ce` input on the board, as a calibrated replacement for the fixed generator.

Parameters:
- CLK_FREQ, 27_000_000, input clock in Hz; must exceed 65535, enforced by an elaboration-time error.
- ACC_W, 32, phase-accumulator width; must satisfy 2^ACC_W > CLK_FREQ + 65535.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  run enable; low freezes generation
- load  input  1  one-cycle strobe; captures `freq`
- freq  input  16  requested rate in pulses/s (binary; BCD when the optional feature is on)
- busy  output  1  high while a load is being applied; further loads are ignored
- ceo  output  1  one-cycle output pulse stream
- sec_tick  output  1  one-cycle pulse every CLK_FREQ enabled cycles
- err  output  1  sticky invalid-input flag (optional feature only; otherwise tied 0)

Behaviour:
- Reset (async, all registers):
  - outputs: `ceo`=0, `sec_tick`=0, `busy`=0, `err`=0
  - internal: acc=0, sec_cnt=0, f_act=0, state=IDLE
  - With f_act=0 the block produces no `ceo`.
- State machine: IDLE, CONV, APPLY, RUN. IDLE and RUN share generation logic; the state only gates loading.
- Load acceptance:
  - `load`=1 while `busy`=0 → capture `freq` into f_pend.
  - Binary build: go to APPLY; `busy`=1 for exactly 1 cycle.
  - APPLY, one cycle: f_act<=f_pend, acc<=0, sec_cnt<=0, `ceo`/`sec_tick` forced 0; then RUN.
  - `load` while `busy`=1 → ignored, no queuing.
  - Loads are accepted regardless of `en`.
- Generation, every cycle in IDLE/RUN with `en`=1:
  - sum = acc + f_act (ACC_W bits, unsigned, no overflow by construction).
  - If sum >= CLK_FREQ: acc<=sum-CLK_FREQ and `ceo`<=1; else acc<=sum and `ceo`<=0.
  - `ceo` is registered, so it appears 1 cycle after the crossing cycle.
  - sec_cnt counts 0..CLK_FREQ-1; on wrap, `sec_tick`<=1 (registered, same timing as `ceo`).
  - Invariant: exactly f_act `ceo` pulses lie between consecutive `sec_tick` pulses, counting a `ceo` coincident with the closing `sec_tick` as inside the window.
  - Consecutive `ceo` spacing is floor or ceil of CLK_FREQ/f_act cycles.
- `en`=0: acc and sec_cnt hold, `ceo`=`sec_tick`=0. When `en` returns high, generation resumes from the held phase with no catch-up burst.
- f_act=0: acc stays 0; `sec_tick` keeps running.
- Rate change takes effect only at APPLY: phase and gate restart together, with no partial pulse.
- `rst` asserted mid-conversion or mid-run returns to the reset state immediately.

Optional Feature:
- Macro: PULSE_SYNTH_BCD_IN_EN.
- Defined:
  - `freq` is 4 packed BCD digits [15:12]..[3:0].
  - Load goes to CONV: 4 cycles, MSD first, r<=r*10+digit, implemented as (r<<3)+(r<<1)+digit.
  - Then APPLY; `busy`=1 for 5 cycles total.
  - A digit >9 is clamped to 9 and `err` is set; `err` clears on the next accepted load.
- Undefined: no CONV state; `freq` is binary; `err` is constant 0.

Decomposition:
- Package pulse_synth_pkg: state enum (IDLE, CONV, APPLY, RUN) and the constants BCD_DIGITS=4 and MAX_FREQ=16'hFFFF.
- One sub-module: pulse_synth_bcd2bin, a sequential BCD→binary converter with start/done/err, instantiated only under the macro.
- Accumulator, gate counter and FSM stay in the top module.

Test Plan:
- CLK_FREQ=100_000, load freq=1000, en=1 → `busy` for 1 cycle; `ceo` every exactly 100 cycles; 1000 `ceo` between consecutive `sec_tick` pulses, with `sec_tick` every 100_000 cycles.
- freq=3 → `ceo` spacings of 33333 or 33334 cycles; exactly 3 per gate window; acc never ≥ CLK_FREQ.
- Running at 1000, pulse `en` low for 250 cycles → no `ceo`/`sec_tick` during that time; after resume, next `ceo` arrives at the remaining phase distance; total count per window still 1000.
- Load 500 mid-window, plus a second load during `busy` → second load ignored; acc and sec_cnt zeroed; next window contains exactly 500 pulses.
- freq=0 → no `ceo`; `sec_tick` continues; assert `rst` mid-window → all outputs 0 immediately, no pulses until the next load.
- (BCD build) load 16'h1234 → `busy` for 5 cycles, f_act=1234, `err`=0; load 16'h12A4 → f_act=1294, `err`=1 until the next load.
